spi_master_engine: RTL
======================

Name: spi_master_engine

Overview:
SPI master bit engine (mode 0: CPOL=0, CPHA=0, MSB first) that drives the slave-side SPI core. It generates SS and SCK, shifts MOSI out and samples MISO for one DATAWIDTH_BUS-bit frame per start request. It sits between a host-side request/ready interface and the four SPI pins, and is the counterpart of the slave's SCK pulse counting.

Parameters:
DATAWIDTH_BUS, 8, frame/data width in bits (>=2)
STATE_SIZE, 3, state register width
SCK_HALF_PERIOD, 4, CLOCK_50 cycles per SCK half period (>=1); SCK = 50 MHz / (2*SCK_HALF_PERIOD)
DIV_SIZE, 8, half-period counter width; must hold SCK_HALF_PERIOD-1

Ports:
SPI_MASTER_ENGINE_CLOCK_50  in  1  system clock, all logic on rising edge
SPI_MASTER_ENGINE_RESET_InLow  in  1  synchronous active-low reset
SPI_MASTER_ENGINE_START_InHigh  in  1  frame request, sampled only while READY=1
SPI_MASTER_ENGINE_txData_In  in  DATAWIDTH_BUS  word to send, latched on accepted START
SPI_MASTER_ENGINE_rxData_Out  out  DATAWIDTH_BUS  last complete received word
SPI_MASTER_ENGINE_pulseCount_Out  out  DATAWIDTH_BUS  SCK rising edges issued in current/last frame
SPI_MASTER_ENGINE_READY_OutHigh  out  1  engine idle, START accepted
SPI_MASTER_ENGINE_DONE_OutHigh  out  1  one-cycle pulse, frame complete
SPI_MASTER_ENGINE_SCK_Out  out  1  serial clock
SPI_MASTER_ENGINE_MOSI_Out  out  1  serial data out
SPI_MASTER_ENGINE_MISO_In  in  1  serial data in
SPI_MASTER_ENGINE_SS_OutLow  out  1  slave select, active low

Behaviour:
- Reset is synchronous: RESET_InLow=0 at a clock edge sets state IDLE, SS=1, SCK=0, MOSI=0, rxData=0, pulseCount=0, READY=1, DONE=0, divider=0, bit counter=0. This applies mid-frame as well: the frame is aborted, no DONE is issued, and rxData is not updated.
- All outputs are registered. No combinational path runs from inputs to outputs.
- States:
  - IDLE: READY=1. On START=1, latch txData into tx shift register, SS<=0, MOSI<=txData[MSB], READY<=0, pulseCount<=0, rx shift<=0, go to LEAD.
  - LEAD: SCK=0 for SCK_HALF_PERIOD cycles, then SCK<=1, rx shift <= {rx[W-2:0], MISO}, pulseCount++, go to HIGH.
  - HIGH: SCK=1 for SCK_HALF_PERIOD cycles, then SCK<=0.
    - If pulseCount==DATAWIDTH_BUS, go to TRAIL.
    - Otherwise shift tx left, MOSI<=next bit, go to LOW.
  - LOW: SCK=0 for SCK_HALF_PERIOD cycles, then SCK<=1, sample MISO as in LEAD, pulseCount++, go to HIGH.
  - TRAIL: SCK=0, SS=0 for SCK_HALF_PERIOD cycles, then SS<=1, MOSI<=0, rxData<=rx shift, DONE<=1, READY<=1, go to IDLE.
- DONE is high exactly one cycle: the first IDLE cycle. A START in that cycle is accepted, so back-to-back frames have SS high for exactly 1 cycle.
- SS low duration per frame is exactly (2*DATAWIDTH_BUS+1)*SCK_HALF_PERIOD cycles. Exactly DATAWIDTH_BUS SCK rising edges occur per frame.
- MOSI changes only when SCK falls or SS falls. MISO is sampled on the clock edge that raises SCK.
- START and txData are ignored while READY=0. txData changes mid-frame have no effect.
- rxData and pulseCount hold their values between frames. pulseCount saturates at DATAWIDTH_BUS by construction, with no wrap.
- The divider counts 0..SCK_HALF_PERIOD-1 and clears on every state change. With SCK_HALF_PERIOD=1, each state lasts 1 cycle.
- Unused state encodings go to IDLE with SS=1.

Decomposition:
- Shared package spi_pkg: state encodings (IDLE=3'b000, LEAD=3'b001, HIGH=3'b010, LOW=3'b011, TRAIL=3'b100), DATAWIDTH_BUS default, SPI mode constants (CPOL=0, CPHA=0, MSB_FIRST=1).
- One sub-module, spi_half_period_timer: divider counter with clear input and one-cycle terminal-count output, parameterised by SCK_HALF_PERIOD/DIV_SIZE, same clock and sync active-low reset.

Test Plan:
- Reset: pull RESET_InLow low for 3 cycles mid-frame (after 3 SCK edges) -> next edge SS=1, SCK=0, MOSI=0, READY=1, DONE=0, rxData=0x00, pulseCount=0; no DONE afterwards.
- Single frame, default params: txData=0xA5, MISO slave model returns 0x3C -> MOSI at the 8 SCK rising edges = 1,0,1,0,0,1,0,1; SS low 68 cycles; DONE one cycle; rxData=0x3C; pulseCount=8.
- Back-to-back: START held high, txData=0xFF then 0x00 -> two frames, SS high exactly 1 cycle between; rxData updated only at each DONE.
- Busy ignore: START pulse and txData=0x11 issued mid-frame of 0xC3 -> frame still shifts 0xC3; no extra frame starts; READY stays 0 until DONE.
- SCK_HALF_PERIOD=1 instance: txData=0x81, MISO tied 1 -> SCK toggles every cycle; SS low 17 cycles; rxData=0xFF.
- Boundary data: txData=0x00 with MISO=0, then txData=0xFF with MISO=1 -> MOSI constant per frame; rxData=0x00 then 0xFF; MOSI=0 in IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine: FSM encodings, default widths
// and the fixed SPI mode (mode 0, MSB first).
package spi_pkg;

  localparam int DATAWIDTH_BUS_DEFAULT = 8;
  localparam int STATE_SIZE_DEFAULT    = 3;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_LEAD  = 3'b001,
    ST_HIGH  = 3'b010,
    ST_LOW   = 3'b011,
    ST_TRAIL = 3'b100
  } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// SCK half-period divider: counts 0..SCK_HALF_PERIOD-1 and flags the last
// count for one cycle. Held at zero while clear is high.
module spi_half_period_timer #(
  parameter int SCK_HALF_PERIOD = 4,
  parameter int DIV_SIZE        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam logic [DIV_SIZE-1:0] LAST = DIV_SIZE'(SCK_HALF_PERIOD - 1);

  logic [DIV_SIZE-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST) && !clear;

endmodule

// File: rtl/spi_master_engine.sv
// Mode-0 SPI master bit engine: one DATAWIDTH_BUS-bit frame per accepted
// START, SS/SCK/MOSI generated from registers, MISO sampled as SCK rises.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int DATAWIDTH_BUS   = DATAWIDTH_BUS_DEFAULT,
  parameter int STATE_SIZE      = STATE_SIZE_DEFAULT,
  parameter int SCK_HALF_PERIOD = 4,
  parameter int DIV_SIZE        = 8
) (
  input  logic                     SPI_MASTER_ENGINE_CLOCK_50,
  input  logic                     SPI_MASTER_ENGINE_RESET_InLow,
  input  logic                     SPI_MASTER_ENGINE_START_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SPI_MASTER_ENGINE_txData_In,
  output logic [DATAWIDTH_BUS-1:0] SPI_MASTER_ENGINE_rxData_Out,
  output logic [DATAWIDTH_BUS-1:0] SPI_MASTER_ENGINE_pulseCount_Out,
  output logic                     SPI_MASTER_ENGINE_READY_OutHigh,
  output logic                     SPI_MASTER_ENGINE_DONE_OutHigh,
  output logic                     SPI_MASTER_ENGINE_SCK_Out,
  output logic                     SPI_MASTER_ENGINE_MOSI_Out,
  input  logic                     SPI_MASTER_ENGINE_MISO_In,
  output logic                     SPI_MASTER_ENGINE_SS_OutLow
);

  localparam int W = DATAWIDTH_BUS;
  localparam logic [W-1:0] FULL_COUNT = W'(W);

  localparam logic [STATE_SIZE-1:0] S_IDLE  = STATE_SIZE'(ST_IDLE);
  localparam logic [STATE_SIZE-1:0] S_LEAD  = STATE_SIZE'(ST_LEAD);
  localparam logic [STATE_SIZE-1:0] S_HIGH  = STATE_SIZE'(ST_HIGH);
  localparam logic [STATE_SIZE-1:0] S_LOW   = STATE_SIZE'(ST_LOW);
  localparam logic [STATE_SIZE-1:0] S_TRAIL = STATE_SIZE'(ST_TRAIL);

  logic                  clk;
  logic                  rst_n;
  logic [STATE_SIZE-1:0] state;
  logic [W-1:0]          tx_shift;
  logic [W-1:0]          rx_shift;
  logic [W-1:0]          rx_data;
  logic [W-1:0]          pulse_count;
  logic                  ready;
  logic                  done;
  logic                  sck;
  logic                  mosi;
  logic                  ss;
  logic                  tc;

  assign clk   = SPI_MASTER_ENGINE_CLOCK_50;
  assign rst_n = SPI_MASTER_ENGINE_RESET_InLow;

  // Divider restarts from zero on every state change: it is held clear in
  // IDLE and wraps on its own terminal count, which is the only exit elsewhere.
  spi_half_period_timer #(
    .SCK_HALF_PERIOD (SCK_HALF_PERIOD),
    .DIV_SIZE        (DIV_SIZE)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == S_IDLE),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ss          <= 1'b1;
      sck         <= CPOL;
      mosi        <= 1'b0;
      rx_data     <= '0;
      pulse_count <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (SPI_MASTER_ENGINE_START_InHigh) begin
            tx_shift    <= SPI_MASTER_ENGINE_txData_In;
            mosi        <= SPI_MASTER_ENGINE_txData_In[W-1];
            ss          <= 1'b0;
            ready       <= 1'b0;
            pulse_count <= '0;
            rx_shift    <= '0;
            state       <= S_LEAD;
          end
        end
        S_LEAD, S_LOW: begin
          if (tc) begin
            sck         <= ~CPOL;
            rx_shift    <= {rx_shift[W-2:0], SPI_MASTER_ENGINE_MISO_In};
            pulse_count <= pulse_count + 1'b1;
            state       <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (tc) begin
            sck <= CPOL;
            if (pulse_count == FULL_COUNT) begin
              state <= S_TRAIL;
            end else begin
              // Rotate rather than shift; the wrapped bit is never sent.
              tx_shift <= {tx_shift[W-2:0], tx_shift[W-1]};
              mosi     <= tx_shift[W-2];
              state    <= S_LOW;
            end
          end
        end
        S_TRAIL: begin
          if (tc) begin
            ss      <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_shift;
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          ss    <= 1'b1;
          sck   <= CPOL;
          mosi  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign SPI_MASTER_ENGINE_rxData_Out     = rx_data;
  assign SPI_MASTER_ENGINE_pulseCount_Out = pulse_count;
  assign SPI_MASTER_ENGINE_READY_OutHigh  = ready;
  assign SPI_MASTER_ENGINE_DONE_OutHigh   = done;
  assign SPI_MASTER_ENGINE_SCK_Out        = sck;
  assign SPI_MASTER_ENGINE_MOSI_Out       = mosi;
  assign SPI_MASTER_ENGINE_SS_OutLow      = ss;

endmodule
